// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch stage and the memory controller.
// Ports: if_mc_en/if_mc_addr (request), mc_if_ready/mc_if_data (completion).
interface instr_fetch_if;
   logic        if_mc_en;
   logic [17:0] if_mc_addr;
   logic        mc_if_ready;
   logic [31:0] mc_if_data;

   modport master (
      output if_mc_en,
      output if_mc_addr,
      input  mc_if_ready,
      input  mc_if_data
   );

   modport slave (
      input  if_mc_en,
      input  if_mc_addr,
      output mc_if_ready,
      output mc_if_data
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory request FSM, one-entry stall buffer.
// Ports: clock, reset, ex_if_stall, id_if_* redirect, mem bus, if_id_* out.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_if_stall,
   input  logic        id_if_selpcsource,
   input  logic [1:0]  id_if_selpctype,
   input  logic [31:0] id_if_pcimd2ext,
   input  logic [31:0] id_if_pcindex,
   input  logic [31:0] id_if_rega,
   instr_fetch_if.master mem,
   output logic [31:0] if_id_instruc,
   output logic [31:0] if_id_nextpc,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {
      S_REQ,
      S_BUF,
      S_FLUSH
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] buf_instr;
   logic [31:0] buf_nextpc;
   logic [31:0] pend_pc;
   logic [31:0] target;
   logic        redirect;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      target = id_if_pcimd2ext;
      unique case (1'b1)
         (id_if_selpctype == 2'b01): target = id_if_pcindex;
         (id_if_selpctype == 2'b10): target = id_if_rega;
         default:                    target = id_if_pcimd2ext;
      endcase
   end

   // Redirects only count against a real instruction in decode,
   // and never while execute holds the pipe.
   assign redirect = id_if_selpcsource && if_id_valid &&
                     !ex_if_stall && (id_if_selpctype != 2'b11);

   assign mem.if_mc_en   = !reset && (state != S_BUF);
   assign mem.if_mc_addr = pc[19:2];

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_REQ;
         pc            <= RESET_PC;
         buf_instr     <= 32'h0;
         buf_nextpc    <= 32'h0;
         pend_pc       <= 32'h0;
         if_id_instruc <= 32'h0;
         if_id_nextpc  <= 32'h0;
         if_id_valid   <= 1'b0;
      end else begin
         // Bubble unless a word is delivered below; a stall freezes IF/ID.
         if (!ex_if_stall) begin
            if_id_valid   <= 1'b0;
            if_id_instruc <= 32'h0;
         end
         unique case (state)
            S_REQ: begin
               if (mem.mc_if_ready) begin
                  if (ex_if_stall) begin
                     buf_instr  <= mem.mc_if_data;
                     buf_nextpc <= pc_plus4;
                     state      <= S_BUF;
                  end else if (redirect) begin
                     pc <= target;
                  end else begin
                     if_id_instruc <= mem.mc_if_data;
                     if_id_nextpc  <= pc_plus4;
                     if_id_valid   <= 1'b1;
                     pc            <= pc_plus4;
                  end
               end else if (redirect) begin
                  // Address must stay put until the old request completes.
                  pend_pc <= target;
                  state   <= S_FLUSH;
               end
            end
            S_BUF: begin
               if (redirect) begin
                  pc    <= target;
                  state <= S_REQ;
               end else if (!ex_if_stall) begin
                  if_id_instruc <= buf_instr;
                  if_id_nextpc  <= buf_nextpc;
                  if_id_valid   <= 1'b1;
                  pc            <= pc_plus4;
                  state         <= S_REQ;
               end
            end
            S_FLUSH: begin
               if (mem.mc_if_ready) begin
                  pc    <= redirect ? target : pend_pc;
                  state <= S_REQ;
               end else if (redirect) begin
                  pend_pc <= target;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ex_if_stall  input  1  pipeline hold request from execute stage.
REQ-005 id_if_selpcsource  input  1  decode redirect request (1 = take target).
REQ-006 id_if_selpctype  input  2  target select: 00 branch, 01 jump, 10 register, 11 none.
REQ-007 id_if_pcimd2ext  input  32  branch target.
REQ-008 id_if_pcindex  input  32  jump target.
REQ-009 id_if_rega  input  32  register-jump target.
REQ-010 if_mc_en  output  1  instruction memory request.
REQ-011 if_mc_addr  output  18  instruction memory word address.
REQ-012 mc_if_ready  input  1  memory completion strobe; mc_if_data valid in the same cycle.
REQ-013 mc_if_data  input  32  instruction word from memory.
REQ-014 if_id_instruc  output  32  registered instruction to decode.
REQ-015 if_id_nextpc  output  32  registered PC+4 of the delivered instruction.
REQ-016 if_id_valid  output  1  registered; 1 = if_id_instruc holds a real instruction.

Function
REQ-017 32-bit PC register; if_mc_addr SHALL equal pc[19:2]; pc[1:0] ignored.
REQ-018 FSM states: REQ (request outstanding), BUF (word captured, stalled), FLUSH (request outstanding, result to be discarded).
REQ-019 if_mc_en SHALL be 1 in REQ and FLUSH, 0 in BUF and while reset=1.
REQ-020 if_mc_addr SHALL remain stable from assertion of if_mc_en until the cycle mc_if_ready=1.
REQ-021 Accepted redirect: id_if_selpcsource=1 AND if_id_valid=1 AND ex_if_stall=0 AND id_if_selpctype!=11; target per REQ-006.
REQ-022 REQ, ready=1, no stall, no redirect: if_id_instruc<=mc_if_data, if_id_nextpc<=pc+4, if_id_valid<=1, pc<=pc+4, stay REQ (one instruction per cycle at zero-wait memory).
REQ-023 REQ, ready=1, ex_if_stall=1: word and pc+4 SHALL be captured in a one-entry buffer, IF/ID unchanged, go BUF.
REQ-024 BUF, ex_if_stall=0, no redirect: IF/ID loaded from buffer with valid=1, pc<=pc+4, go REQ.
REQ-025 BUF, accepted redirect: buffer discarded, pc<=target, IF/ID valid<=0, go REQ.
REQ-026 REQ, ready=0, accepted redirect: target latched into pending register, go FLUSH; address held per REQ-020.
REQ-027 REQ, ready=1 with accepted redirect in the same cycle: returned word discarded, pc<=target, if_id_valid<=0, stay REQ.
REQ-028 FLUSH, ready=1: word discarded, pc<=pending target, go REQ; further redirects in FLUSH SHALL overwrite the pending target.
REQ-029 Any cycle with ex_if_stall=1: if_id_instruc, if_id_nextpc, if_id_valid SHALL hold.
REQ-030 Any cycle with ex_if_stall=0 and no word delivered: if_id_valid<=0, if_id_instruc<=32'h0 (NOP), if_id_nextpc holds.
REQ-031 PC arithmetic modulo 2^32; pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0.
REQ-032 selpctype=11 with selpcsource=1 SHALL be treated as no redirect.

Reset
REQ-033 reset=1 at a rising edge: pc<=RESET_PC, state<=REQ, buffer and pending cleared, if_id_instruc<=0, if_id_nextpc<=0, if_id_valid<=0.
REQ-034 reset SHALL override all other inputs, including mid-request; any mc_if_ready in the reset cycle SHALL be ignored.
REQ-035 First request SHALL issue in the cycle after reset deasserts, at address RESET_PC[19:2].

Verification
REQ-036 Zero-wait memory returning addr-tagged words, no stall -> if_mc_addr 0,1,2,3 on consecutive cycles; if_id_nextpc 4,8,12,16; valid=1 each cycle.
REQ-037 Memory ready after 3 cycles -> addr held 3 cycles; valid=1 one cycle per word, valid=0/instruc=0 in between.
REQ-038 Ready arrives with ex_if_stall=1 for 2 cycles -> state BUF, en=0, IF/ID held; word delivered the cycle after stall drops.
REQ-039 Redirect selpctype=01, pcindex=32'h0000_0100 while request pending -> FLUSH; stale word dropped; next addr 18'h40; one or more bubbles, no stale instruction delivered.
REQ-040 Redirect and ready in same cycle, selpctype=10, rega=32'h0000_0200 -> if_id_valid=0 next cycle, next addr 18'h80.
REQ-041 reset asserted during FLUSH -> next cycle pc=RESET_PC, valid=0, pending target lost, request at RESET_PC[19:2].
